// File: rtl/event_timestamper_fifo.sv
// Per-ID start/end latency timestamper with a FIFO_DEPTH-deep record queue and orphan-end flagging.
// Optional timeout sweep enabled by defining EVT_TS_TIMEOUT_EN.
module event_timestamper_fifo #(
  parameter int unsigned ID_W       = 4,
  parameter int unsigned TS_W       = 64,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TO_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [ID_W-1:0]   start_id,
  input  logic              end_valid,
  output logic              end_ready,
  input  logic [ID_W-1:0]   end_id,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ID_W-1:0]   out_id,
  output logic [TS_W-1:0]   out_start_ts,
  output logic [TS_W-1:0]   out_end_ts,
  output logic [TS_W-1:0]   out_delta,
  output logic              out_orphan,
  output logic              out_timeout
`ifdef EVT_TS_TIMEOUT_EN
  ,
  input  logic [TO_W-1:0]   timeout_cycles
`endif
);

  localparam int unsigned NUM_IDS = 1 << ID_W;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [TS_W-1:0] start_ts;
    logic [TS_W-1:0] end_ts;
    logic [TS_W-1:0] delta;
    logic            orphan;
    logic            timeout;
  } rec_t;

  logic [TS_W-1:0]    cnt;
  logic [NUM_IDS-1:0] active, active_d;
  logic [TS_W-1:0]    start_mem [NUM_IDS];
  rec_t               stage, stage_d, head, head_d;
  logic               stage_valid, stage_valid_d;
  rec_t               fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr, rd_next;
  logic [CNT_W-1:0]   fifo_count, count_after_pop, count_next;
  logic               space, end_fire, start_fire, push, pop;
  logic               sweep_fire;

  // Credit covers both the stage register and every queued record, including the output head.
  assign space       = (32'(fifo_count) + 32'(stage_valid)) < FIFO_DEPTH;
  assign end_ready   = space;
  assign end_fire    = end_valid && space;
  assign start_ready = !active[start_id] || (end_fire && (end_id == start_id));
  assign start_fire  = start_valid && start_ready;

`ifdef EVT_TS_TIMEOUT_EN
  logic [ID_W-1:0] sweep_ptr;
  logic [TS_W-1:0] elapsed;
  logic            sweep_hit;

  assign elapsed    = cnt - start_mem[sweep_ptr];
  assign sweep_hit  = active[sweep_ptr] && (timeout_cycles != '0) &&
                      (elapsed >= TS_W'(timeout_cycles));
  assign sweep_fire = sweep_hit && space && !end_fire &&
                      !(start_fire && (start_id == sweep_ptr));

  // A blocked hit parks the pointer so the expired ID is retried next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       sweep_ptr <= '0;
    else if (!sweep_hit || sweep_fire) sweep_ptr <= sweep_ptr + ID_W'(1);
  end
`else
  assign sweep_fire = 1'b0;
`endif

  // Next stage record and scoreboard update; end path outranks the sweep, start wins over clear.
  always_comb begin
    stage_d       = stage;
    stage_valid_d = 1'b0;
    active_d      = active;
    if (end_fire) begin
      stage_valid_d    = 1'b1;
      stage_d.id       = end_id;
      stage_d.orphan   = !active[end_id];
      stage_d.start_ts = active[end_id] ? start_mem[end_id] : '0;
      stage_d.end_ts   = cnt;
      stage_d.delta    = active[end_id] ? (cnt - start_mem[end_id]) : '0;
      stage_d.timeout  = 1'b0;
      active_d[end_id] = 1'b0;
    end
`ifdef EVT_TS_TIMEOUT_EN
    else if (sweep_fire) begin
      stage_valid_d       = 1'b1;
      stage_d.id          = sweep_ptr;
      stage_d.orphan      = 1'b0;
      stage_d.start_ts    = start_mem[sweep_ptr];
      stage_d.end_ts      = cnt;
      stage_d.delta       = elapsed;
      stage_d.timeout     = 1'b1;
      active_d[sweep_ptr] = 1'b0;
    end
`endif
    if (start_fire) active_d[start_id] = 1'b1;
  end

  // FIFO bookkeeping; the output register always mirrors the entry at the read pointer.
  always_comb begin
    pop             = out_valid && out_ready;
    push            = stage_valid;
    count_after_pop = fifo_count - CNT_W'(pop);
    count_next      = count_after_pop + CNT_W'(push);
    rd_next         = rd_ptr + PTR_W'(pop);
    head_d          = (count_after_pop == '0) ? stage : fifo_mem[rd_next];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      active      <= '0;
      stage       <= '0;
      stage_valid <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_count  <= '0;
      head        <= '0;
      out_valid   <= 1'b0;
    end else begin
      cnt         <= cnt + TS_W'(1);
      active      <= active_d;
      stage       <= stage_d;
      stage_valid <= stage_valid_d;
      rd_ptr      <= rd_next;
      wr_ptr      <= wr_ptr + PTR_W'(push);
      fifo_count  <= count_next;
      out_valid   <= (count_next != '0);
      if (count_next != '0) head <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (start_fire) start_mem[start_id] <= cnt;
    if (push)       fifo_mem[wr_ptr]    <= stage;
  end

  assign out_id       = head.id;
  assign out_start_ts = head.start_ts;
  assign out_end_ts   = head.end_ts;
  assign out_delta    = head.delta;
  assign out_orphan   = head.orphan;
  assign out_timeout  = head.timeout;

endmodule
